// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_ctrl
// Purpose  : Resolves conditional branches and jumps from the execute stage,
//            trains a table of 2-bit direction counters, and issues a
//            registered fetch redirect plus a one-cycle IF/ID flush on a
//            misprediction. Keeps saturating branch/mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    // execute-stage resolution
    input  logic             ex_valid_i,
    input  logic             ex_is_b_type_i,
    input  logic             ex_is_jump_i,
    input  logic [63:0]      ex_pc_i,
    input  logic [63:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic             branch_taken_i,
    // fetch-side prediction lookup
    input  logic [63:0]      pred_pc_i,
    output logic             pred_taken_o,
    // fetch redirect
    output logic             redirect_valid_o,
    output logic [63:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             flush_o,
    // statistics
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    localparam int              C_BHT_ENTRIES = 1 << BHT_IDX_W;
    localparam logic [1:0]      C_BHT_INIT    = 2'b01;   // weakly not-taken
    localparam logic [1:0]      C_BHT_MAX     = 2'b11;
    localparam logic [1:0]      C_BHT_MIN     = 2'b00;
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [1:0]             r_bht [C_BHT_ENTRIES];
    logic [63:0]            r_redirect_pc;
    logic                   r_flush;
    logic [CNT_W-1:0]       r_branch_cnt;
    logic [CNT_W-1:0]       r_mispredict_cnt;

    logic                   w_in_idle;
    logic                   w_is_ctrl;
    logic                   w_resolve;
    logic                   w_actual_taken;
    logic                   w_mispredict;
    logic [63:0]            w_correct_pc;
    logic                   w_bht_update;
    logic [BHT_IDX_W-1:0]   w_upd_idx;
    logic [BHT_IDX_W-1:0]   w_pred_idx;
    logic [1:0]             w_bht_cur;
    logic [1:0]             w_bht_next;
    logic                   w_handshake;
    logic                   w_unused_pred_bits;

    // Decode of the execute-stage event. Instructions seen while a redirect
    // is outstanding are on the wrong path, so resolution is gated to IDLE.
    // A jump always counts as taken, which also makes an instruction flagged
    // as both branch and jump behave as a jump.
    always_comb begin
        w_in_idle      = (r_state == ST_IDLE);
        w_is_ctrl      = ex_is_b_type_i | ex_is_jump_i;
        w_resolve      = ex_valid_i & w_is_ctrl & w_in_idle;
        w_actual_taken = ex_is_jump_i | branch_taken_i;
        w_mispredict   = w_resolve & (w_actual_taken != ex_pred_taken_i);
        w_correct_pc   = w_actual_taken ? ex_target_i : (ex_pc_i + 64'd4);
        w_bht_update   = w_resolve & ex_is_b_type_i & ~ex_is_jump_i;
        w_handshake    = (r_state == ST_REDIRECT) & redirect_ready_i;
    end

    // Table indices: instructions are word aligned, so PC[1:0] is skipped.
    assign w_upd_idx  = ex_pc_i[BHT_IDX_W+1:2];
    assign w_pred_idx = pred_pc_i[BHT_IDX_W+1:2];

    // Upper and alignment bits of the lookup PC do not take part in indexing.
    assign w_unused_pred_bits = ^{pred_pc_i[63:BHT_IDX_W+2], pred_pc_i[1:0]};

    // Saturating 2-bit counter step for the entry being trained.
    always_comb begin
        w_bht_cur  = r_bht[w_upd_idx];
        w_bht_next = w_bht_cur;
        if (branch_taken_i) begin
            if (w_bht_cur != C_BHT_MAX) begin
                w_bht_next = w_bht_cur + 2'b01;
            end
        end else begin
            if (w_bht_cur != C_BHT_MIN) begin
                w_bht_next = w_bht_cur - 2'b01;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: enter REDIRECT on a mispredict, leave on handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mispredict) begin
                    w_state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (w_handshake) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Redirect target and flush pulse. The flush is raised only by a
    // mispredict, which can only happen in IDLE, so it is naturally confined
    // to the first REDIRECT cycle. The target is captured once and then held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_pc <= 64'd0;
            r_flush       <= 1'b0;
        end else begin
            r_flush <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_correct_pc;
            end
        end
    end

    // Direction table training; jumps and wrong-path instructions are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_BHT_ENTRIES; i++) begin
                r_bht[i] <= C_BHT_INIT;
            end
        end else if (w_bht_update) begin
            r_bht[w_upd_idx] <= w_bht_next;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_resolve && (r_branch_cnt != C_CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + C_CNT_ONE;
            end
            if (w_mispredict && (r_mispredict_cnt != C_CNT_MAX)) begin
                r_mispredict_cnt <= r_mispredict_cnt + C_CNT_ONE;
            end
        end
    end

    // Lookup reads the registered table, so a same-cycle update to the same
    // entry is not visible until the following cycle.
    assign pred_taken_o     = r_bht[w_pred_idx][1];
    assign redirect_valid_o = (r_state == ST_REDIRECT);
    assign redirect_pc_o    = r_redirect_pc;
    assign flush_o          = r_flush;
    assign branch_cnt_o     = r_branch_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_ctrl
// Purpose  : Self-checking bench for branch_resolve_ctrl: directed vector
//            table, hand-written multi-cycle sequences and a randomized run
//            against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    localparam int BHT_IDX_W = 4;
    localparam int CNT_W     = 5;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int NENT      = 1 << BHT_IDX_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid_i, ex_is_b_type_i, ex_is_jump_i;
    logic [63:0]      ex_pc_i, ex_target_i;
    logic             ex_pred_taken_i, branch_taken_i;
    logic [63:0]      pred_pc_i;
    logic             pred_taken_o;
    logic             redirect_valid_o;
    logic [63:0]      redirect_pc_o;
    logic             redirect_ready_i;
    logic             flush_o;
    logic [CNT_W-1:0] branch_cnt_o, mispredict_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    branch_resolve_ctrl #(.BHT_IDX_W(BHT_IDX_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid_i       (ex_valid_i),
        .ex_is_b_type_i   (ex_is_b_type_i),
        .ex_is_jump_i     (ex_is_jump_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .branch_taken_i   (branch_taken_i),
        .pred_pc_i        (pred_pc_i),
        .pred_taken_o     (pred_taken_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .flush_o          (flush_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, v, b, j;
        logic [63:0] pc, tgt;
        logic        pred, tk, rdy;
        logic [63:0] ppc;
        logic        e_rv;
        logic [63:0] e_rpc;
        logic        e_fl, e_pt;
        int          e_bc, e_mc;
    } vec_t;

    vec_t vecs[13];

    // ---------------- behavioural reference model ----------------
    bit        m_busy;      // a redirect is outstanding
    bit        m_flush;
    longint unsigned m_rpc;
    int        m_bht[NENT];
    int        m_bc, m_mc;

    function automatic int idx_of(logic [63:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic void m_reset();
        m_busy = 0; m_flush = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
        for (int i = 0; i < NENT; i++) m_bht[i] = 1;
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    function automatic void m_step();
        bit actual;
        int k;
        if (reset) begin
            m_reset();
            return;
        end
        if (m_busy) begin
            m_flush = 0;
            if (redirect_ready_i) m_busy = 0;
            return;
        end
        m_flush = 0;
        if (ex_valid_i && (ex_is_b_type_i || ex_is_jump_i)) begin
            m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
            actual = ex_is_jump_i ? 1'b1 : branch_taken_i;
            if (ex_is_b_type_i && !ex_is_jump_i) begin
                k = idx_of(ex_pc_i);
                if (branch_taken_i) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
                else                m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
            end
            if (actual != ex_pred_taken_i) begin
                m_mc    = (m_mc < CNT_MAX) ? m_mc + 1 : CNT_MAX;
                m_busy  = 1;
                m_flush = 1;
                m_rpc   = actual ? ex_target_i : ex_pc_i + 64'd4;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic b, input logic j,
                         input logic [63:0] pc, input logic [63:0] tgt,
                         input logic pred, input logic tk, input logic rdy,
                         input logic [63:0] ppc);
        reset = rst; ex_valid_i = v; ex_is_b_type_i = b; ex_is_jump_i = j;
        ex_pc_i = pc; ex_target_i = tgt; ex_pred_taken_i = pred;
        branch_taken_i = tk; redirect_ready_i = rdy; pred_pc_i = ppc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic rst, logic v, logic b, logic j, logic [63:0] pc,
                                logic [63:0] tgt, logic pred, logic tk, logic rdy,
                                logic [63:0] ppc, logic e_rv, logic [63:0] e_rpc,
                                logic e_fl, logic e_pt, int e_bc, int e_mc);
        vec_t r;
        r.rst = rst; r.v = v; r.b = b; r.j = j; r.pc = pc; r.tgt = tgt;
        r.pred = pred; r.tk = tk; r.rdy = rdy; r.ppc = ppc;
        r.e_rv = e_rv; r.e_rpc = e_rpc; r.e_fl = e_fl; r.e_pt = e_pt;
        r.e_bc = e_bc; r.e_mc = e_mc;
        return r;
    endfunction

    initial begin
        // Expected values are the outputs observed just after the edge that
        // consumes each row's inputs.
        //            rst v b j  pc       tgt      pr tk rdy ppc      rv rpc      fl pt bc mc
        vecs[0]  = mk(1, 0,0,0, 64'h0,    64'h0,    0,0,0, 64'h40,   0, 64'h0,    0,0, 0,0);
        vecs[1]  = mk(0, 1,1,0, 64'h1000, 64'h2000, 0,1,1, 64'h1000, 1, 64'h2000, 1,1, 1,1);
        vecs[2]  = mk(0, 0,0,0, 64'h0,    64'h0,    0,0,1, 64'h1000, 0, 64'h2000, 0,1, 1,1);
        vecs[3]  = mk(0, 1,1,0, 64'h1000, 64'h2000, 1,0,0, 64'h1000, 1, 64'h1004, 1,0, 2,2);
        vecs[4]  = mk(0, 1,1,0, 64'h1000, 64'h2000, 1,0,0, 64'h1000, 1, 64'h1004, 0,0, 2,2);
        vecs[5]  = mk(0, 1,1,0, 64'h1000, 64'h2000, 1,0,0, 64'h1000, 1, 64'h1004, 0,0, 2,2);
        vecs[6]  = mk(0, 1,1,0, 64'h1000, 64'h2000, 1,0,1, 64'h1000, 0, 64'h1004, 0,0, 2,2);
        vecs[7]  = mk(0, 1,0,1, 64'h80,   64'h3000, 0,0,1, 64'h80,   1, 64'h3000, 1,0, 3,3);
        vecs[8]  = mk(0, 0,0,0, 64'h0,    64'h0,    0,0,1, 64'h80,   0, 64'h3000, 0,0, 3,3);
        vecs[9]  = mk(0, 1,1,1, 64'h44,   64'h600,  1,0,0, 64'h44,   0, 64'h3000, 0,0, 4,3);
        vecs[10] = mk(0, 1,1,0, 64'h48,   64'h700,  0,0,0, 64'h48,   0, 64'h3000, 0,0, 5,3);
        vecs[11] = mk(0, 1,1,0, 64'h48,   64'h500,  0,1,0, 64'h48,   1, 64'h500,  1,0, 6,4);
        vecs[12] = mk(1, 1,1,0, 64'h48,   64'h500,  0,1,0, 64'h48,   0, 64'h0,    0,0, 0,0);

        drive(1, 0,0,0, 0, 0, 0,0,0, 0);
        tick();

        // ---------------- table-driven directed vectors ----------------
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].b, vecs[i].j, vecs[i].pc, vecs[i].tgt,
                  vecs[i].pred, vecs[i].tk, vecs[i].rdy, vecs[i].ppc);
            tick();
            chk($sformatf("vec%0d redirect_valid", i), 64'(redirect_valid_o), 64'(vecs[i].e_rv));
            chk($sformatf("vec%0d redirect_pc", i), redirect_pc_o, vecs[i].e_rpc);
            chk($sformatf("vec%0d flush", i), 64'(flush_o), 64'(vecs[i].e_fl));
            chk($sformatf("vec%0d pred_taken", i), 64'(pred_taken_o), 64'(vecs[i].e_pt));
            chk($sformatf("vec%0d branch_cnt", i), 64'(branch_cnt_o), 64'(vecs[i].e_bc));
            chk($sformatf("vec%0d mispredict_cnt", i), 64'(mispredict_cnt_o), 64'(vecs[i].e_mc));
        end

        // After the reset in the last row every entry must read not-taken.
        drive(0, 0,0,0, 0, 0, 0,0,0, 0);
        for (int i = 0; i < NENT; i++) begin
            pred_pc_i = 64'(i) << 2;
            #1;
            chk($sformatf("post-reset pred idx%0d", i), 64'(pred_taken_o), 64'd0);
        end
        tick();

        // ---------------- BHT saturation at pc 0x40 ----------------
        drive(1, 0,0,0, 0, 0, 0,0,0, 64'h40);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1,1,0, 64'h40, 64'h900, 1,1,0, 64'h40);
            #1;
            chk($sformatf("bht taken%0d pre-update pred", k), 64'(pred_taken_o), (k == 0) ? 64'd0 : 64'd1);
            tick();
            chk($sformatf("bht taken%0d pred", k), 64'(pred_taken_o), 64'd1);
            chk($sformatf("bht taken%0d no redirect", k), 64'(redirect_valid_o), 64'd0);
        end
        // From a saturated 3, two not-taken steps reach 1 (pred 1, then 0).
        for (int k = 0; k < 2; k++) begin
            drive(0, 1,1,0, 64'h40, 64'h900, 0,0,0, 64'h40);
            tick();
            chk($sformatf("bht nottaken%0d pred", k), 64'(pred_taken_o), (k == 0) ? 64'd1 : 64'd0);
        end

        // ---------------- counter saturation ----------------
        drive(1, 0,0,0, 0, 0, 0,0,0, 0);
        tick();
        for (int k = 0; k < CNT_MAX + 8; k++) begin
            drive(0, 1,0,1, 64'h200, 64'h300, 1,0,1, 0);   // correctly predicted jump
            tick();
        end
        chk("branch_cnt saturated", 64'(branch_cnt_o), 64'(CNT_MAX));
        chk("mispredict_cnt still zero", 64'(mispredict_cnt_o), 64'd0);
        for (int k = 0; k < CNT_MAX + 8; k++) begin
            drive(0, 1,0,1, 64'h200, 64'h300, 0,0,1, 0);   // mispredicted jump
            tick();
            drive(0, 0,0,0, 0, 0, 0,0,1, 0);              // redirect accepted
            tick();
        end
        chk("mispredict_cnt saturated", 64'(mispredict_cnt_o), 64'(CNT_MAX));
        chk("branch_cnt holds saturated", 64'(branch_cnt_o), 64'(CNT_MAX));

        // ---------------- randomized run against the model ----------------
        drive(1, 0,0,0, 0, 0, 0,0,0, 0);
        m_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] pc, ppc;
            int kind;
            pc = {$urandom, $urandom} & ~64'd3;
            if ($urandom_range(0, 15) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
            ppc = ($urandom_range(0, 1) == 1) ? pc : ({$urandom, $urandom} & ~64'd3);
            kind = $urandom_range(0, 7);
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  (kind >= 1 && kind <= 4) || kind == 7,
                  (kind == 5 || kind == 6 || kind == 7),
                  pc, {$urandom, $urandom} & ~64'd3,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ppc);
            #1;
            chk("rand pred_taken pre-edge", 64'(pred_taken_o), 64'(m_bht[idx_of(ppc)] >= 2));
            @(posedge clk);
            m_step();
            #1;
            chk("rand redirect_valid", 64'(redirect_valid_o), 64'(m_busy));
            chk("rand redirect_pc", redirect_pc_o, m_rpc);
            chk("rand flush", 64'(flush_o), 64'(m_flush));
            chk("rand branch_cnt", 64'(branch_cnt_o), 64'(m_bc));
            chk("rand mispredict_cnt", 64'(mispredict_cnt_o), 64'(m_mc));
            chk("rand pred_taken post-edge", 64'(pred_taken_o), 64'(m_bht[idx_of(ppc)] >= 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have parameter BHT_IDX_W, default 4, the log2 of the branch history table entry count (16 entries).
REQ-002 The block SHALL have parameter CNT_W, default 32, the width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ex_valid_i  input  1  execute stage presents a resolved control-flow instruction this cycle.
REQ-006 ex_is_b_type_i  input  1  the instruction is a conditional branch.
REQ-007 ex_is_jump_i  input  1  the instruction is JAL/JALR (always taken).
REQ-008 ex_pc_i  input  64  PC of the resolving instruction.
REQ-009 ex_target_i  input  64  computed taken target.
REQ-010 ex_pred_taken_i  input  1  prediction that fetch used for this instruction.
REQ-011 branch_taken_i  input  1  actual conditional outcome from the branch comparator.
REQ-012 pred_pc_i  input  64  fetch PC for prediction lookup.
REQ-013 pred_taken_o  output  1  predicted direction for pred_pc_i.
REQ-014 redirect_valid_o  output  1  fetch redirect request.
REQ-015 redirect_pc_o  output  64  redirect target.
REQ-016 redirect_ready_i  input  1  fetch accepts the redirect.
REQ-017 flush_o  output  1  one-cycle squash pulse to IF/ID.
REQ-018 branch_cnt_o  output  CNT_W  count of resolved branches and jumps.
REQ-019 mispredict_cnt_o  output  CNT_W  count of mispredictions.

Function
REQ-020 A resolve event SHALL be ex_valid_i=1 AND (ex_is_b_type_i OR ex_is_jump_i) AND state=IDLE.
REQ-021 The actual direction SHALL be 1 for jumps and branch_taken_i for branches.
REQ-022 A mispredict SHALL be a resolve event whose actual direction differs from ex_pred_taken_i.
REQ-023 The correct PC SHALL be ex_target_i if actual=1, otherwise ex_pc_i+4 (mod 2^64).
REQ-024 The FSM SHALL have two states: IDLE and REDIRECT.
REQ-025 The FSM SHALL move IDLE->REDIRECT on a mispredict in cycle N; in cycle N+1 redirect_valid_o=1, redirect_pc_o=the correct PC, and flush_o=1.
REQ-026 flush_o SHALL be high only in the first REDIRECT cycle, for exactly one cycle.
REQ-027 In REDIRECT, redirect_valid_o and redirect_pc_o SHALL be held stable until redirect_valid_o AND redirect_ready_i; the FSM then returns to IDLE at the next edge.
REQ-028 A handshake in the first REDIRECT cycle SHALL be legal and SHALL give a one-cycle redirect.
REQ-029 In REDIRECT, ex_valid_i SHALL be ignored as wrong-path, including the handshake cycle: no BHT update, no counter change, no new redirect.
REQ-030 In IDLE, redirect_valid_o and flush_o SHALL be 0.
REQ-031 The BHT SHALL hold 2^BHT_IDX_W 2-bit saturating counters indexed by PC[BHT_IDX_W+1:2].
REQ-032 On a resolve event with ex_is_b_type_i=1, the entry for ex_pc_i SHALL increment (saturating at 3) if taken, or decrement (saturating at 0) if not taken; jumps SHALL NOT update the BHT.
REQ-033 pred_taken_o SHALL be combinational: bit 1 of the entry indexed by pred_pc_i.
REQ-034 A lookup and an update to the same index in the same cycle SHALL return the pre-update value.
REQ-035 ex_is_b_type_i and ex_is_jump_i both high SHALL be treated as a jump.
REQ-036 branch_cnt_o SHALL increment on every resolve event and mispredict_cnt_o on every mispredict; both SHALL saturate at all-ones.

Reset
REQ-037 Reset SHALL force, at the next edge: state=IDLE, redirect_valid_o=0, flush_o=0, redirect_pc_o=0, both counters 0, and every BHT entry=2'b01 (weakly not-taken).
REQ-038 Reset SHALL take priority over all other events, including in REDIRECT mid-handshake and while ex_valid_i is high; the pending redirect SHALL be dropped.

Verification
REQ-039 Reset, then branch at pc 0x1000, pred=0, taken=1, target 0x2000, ready=1 -> next cycle redirect_valid_o=1, redirect_pc_o=0x2000, flush_o=1; the cycle after that is IDLE; mispredict_cnt_o=1.
REQ-040 Branch at pc 0x1000, pred=1, taken=0, ready=0 for 3 cycles -> redirect_pc_o=0x1004 held for 4 cycles; flush_o high only in the first; ex_valid_i mispredicts during the wait change no state.
REQ-041 Four taken branches at pc 0x40 -> BHT[0] goes 1,2,3,3 and pred_taken_o for pred_pc_i=0x40 becomes 1 after the first update.
REQ-042 JAL with pred=0 -> redirect to ex_target_i; the BHT is unchanged; branch_cnt_o increments.
REQ-043 Assert reset during REDIRECT with ready=0 -> next cycle redirect_valid_o=0, counters 0, pred_taken_o=0 for every PC.
REQ-044 Preload counters near all-ones via repeated events -> they hold at all-ones with no wrap.
